// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, default reset vector and PC stage states.
package mips_pkg;

  localparam int PC_W   = 32;
  localparam int JIDX_W = 26;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic {
    NORMAL = 1'b0,
    SLOT   = 1'b1
  } pc_state_t;

  // Sequential successor; the 32-bit add wraps 32'hFFFF_FFFC to 0 on its own.
  function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Redirect target computation and priority selection (jr > jump > branch).
module pc_target_sel
  import mips_pkg::*;
(
  input  logic [PC_W-1:0]   instr_pc4,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              jr,
  input  logic [PC_W-1:0]   jr_target,
  output logic [PC_W-1:0]   next_target,
  output logic              take,
  output logic              misalign_hit
);

  logic [PC_W-1:0] branch_tgt;
  logic [PC_W-1:0] jump_tgt;
  logic [PC_W-1:0] jr_tgt;

  assign branch_tgt = instr_pc4 + branch_offset;
  assign jump_tgt   = {instr_pc4[PC_W-1:28], jump_index, 2'b00};
  assign jr_tgt     = {jr_target[PC_W-1:2], 2'b00};

  assign take = jr | jump | branch_taken;

  // jr has top priority, so its alignment fault only matters when jr itself is selected.
  assign misalign_hit = jr & (jr_target[1:0] != 2'b00);

  // NOTE: every output of a combinational block gets a value before any branch, so no latch is inferred.
  always_comb begin
    next_target = branch_tgt;
    if (jr) begin
      next_target = jr_tgt;
    end else if (jump) begin
      next_target = jump_tgt;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// MIPS program-counter stage with sequential/branch/jump/jr next-PC selection.
// Define PC_UNIT_DELAY_SLOT_EN for branch-delay-slot semantics (redirect lands after the slot).
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [PC_W-1:0]   instr_pc4,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              jr,
  input  logic [PC_W-1:0]   jr_target,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus4,
  output logic              redirect,
  output logic              misaligned
);

  logic [PC_W-1:0] next_target;
  logic            take;
  logic            misalign_hit;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus4_q, pc_plus4_d;
  logic            redirect_q, redirect_d;
  logic            misaligned_q, misaligned_d;

`ifdef PC_UNIT_DELAY_SLOT_EN
  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pending_target_q, pending_target_d;
`endif

  pc_target_sel u_target_sel (
    .instr_pc4     (instr_pc4),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .next_target   (next_target),
    .take          (take),
    .misalign_hit  (misalign_hit)
  );

  // Stall holds everything, including a high redirect, so defaults are "keep".
  always_comb begin
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    misaligned_d = misaligned_q;
`ifdef PC_UNIT_DELAY_SLOT_EN
    state_d          = state_q;
    pending_target_d = pending_target_q;
`endif
    if (!stall) begin
      pc_d       = seq_pc(pc_q);
      redirect_d = 1'b0;
`ifdef PC_UNIT_DELAY_SLOT_EN
      case (state_q)
        NORMAL: begin
          if (take) begin
            pending_target_d = next_target;
            state_d          = SLOT;
            if (misalign_hit) misaligned_d = 1'b1;
          end
        end
        SLOT: begin
          // Requests in the delay slot are ignored; only the pending target lands.
          pc_d       = pending_target_q;
          redirect_d = 1'b1;
          state_d    = NORMAL;
        end
        default: state_d = NORMAL;
      endcase
`else
      if (take) begin
        pc_d       = next_target;
        redirect_d = 1'b1;
        if (misalign_hit) misaligned_d = 1'b1;
      end
`endif
    end
    pc_plus4_d = seq_pc(pc_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pc_plus4_q   <= seq_pc(RESET_PC);
      redirect_q   <= 1'b0;
      misaligned_q <= 1'b0;
`ifdef PC_UNIT_DELAY_SLOT_EN
      state_q          <= NORMAL;
      pending_target_q <= '0;
`endif
    end else begin
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_plus4_d;
      redirect_q   <= redirect_d;
      misaligned_q <= misaligned_d;
`ifdef PC_UNIT_DELAY_SLOT_EN
      state_q          <= state_d;
      pending_target_q <= pending_target_d;
`endif
    end
  end

  assign pc         = pc_q;
  assign pc_plus4   = pc_plus4_q;
  assign redirect   = redirect_q;
  assign misaligned = misaligned_q;

endmodule
